bht_assoc_param: RTL and testbench

- Parametrised set-associative branch history table / branch target buffer for the RV32IMC fetch path; successor to the fixed 64-entry 4-way predictor.
- Predicts in IF, allocates in ID, resolves and trains in EXE, and drives next-PC correction plus pipeline flush.
- Adds:
  - parametrised sets, ways, PC width and counter width
  - invalid-way-first victim selection, with FIFO or LFSR replacement
  - a multi-cycle invalidate-all sweep FSM
- All PCs are word addresses.

---
 rtl/bht_assoc_param.sv | 232 +++++++++++++++++++++++
 tb/tb_bht_assoc_param.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bht_assoc_param.sv
// Set-associative branch history/target table: combinational lookups in IF/ID/EXE,
// allocation from ID and counter training from EXE land on the next enabled CLK edge.
module bht_assoc_param #(
    parameter int PC_W  = 10,
    parameter int SET_W = 4,
    parameter int WAY_W = 2,
    parameter int CTR_W = 2,
    parameter int REPL  = 0
) (
    input  logic            CLK,
    input  logic            nrst,
    input  logic            en,
    input  logic            stall,
    input  logic            isr_running,
    input  logic            inv_req,
    output logic            inv_busy,
    input  logic [PC_W-1:0] if_pc,
    output logic            if_hit,
    output logic            if_prediction,
    output logic [PC_W-1:0] if_pbt,
    input  logic [PC_W-1:0] id_pc,
    input  logic [PC_W-1:0] id_target,
    input  logic            id_is_jump,
    input  logic            id_is_btype,
    output logic            id_jump_in_bht,
    input  logic [PC_W-1:0] exe_pc,
    input  logic            exe_is_branch,
    input  logic            exe_taken,
    output logic [1:0]      exe_correction,
    output logic [PC_W-1:0] exe_pbt,
    output logic [PC_W-1:0] exe_cni,
    output logic            flush
);

    localparam int SETS  = 1 << SET_W;
    localparam int WAYS  = 1 << WAY_W;
    localparam int TAG_W = PC_W - SET_W + 1;
    localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0] CTR_WEAK = CTR_MAX >> 1;

    typedef enum logic {S_IDLE, S_SWEEP} state_t;

    typedef struct packed {
        logic             hit;
        logic [WAY_W-1:0] way;
    } look_t;

    logic [WAYS-1:0]  r_valid [SETS];
    logic [TAG_W-1:0] r_tag   [SETS][WAYS];
    logic [PC_W-1:0]  r_tgt   [SETS][WAYS];
    logic [CTR_W-1:0] r_ctr   [SETS][WAYS];
    logic [WAY_W-1:0] r_fifo  [SETS];
    logic [7:0]       r_lfsr;
    logic             r_flush_state;
    logic [SET_W-1:0] r_sweep_idx;
    state_t           r_state;
    state_t           w_state_nxt;

    logic             w_busy;
    look_t            w_if_lk;
    look_t            w_id_lk;
    look_t            w_exe_lk;
    logic [SET_W-1:0] w_if_set;
    logic [SET_W-1:0] w_id_set;
    logic [SET_W-1:0] w_exe_set;
    logic             w_if_hit;
    logic             w_id_hit;
    logic             w_exe_hit;
    logic [CTR_W-1:0] w_exe_ctr;
    logic [CTR_W-1:0] w_ctr_trained;
    logic [CTR_W-1:0] w_alloc_ctr;
    logic             w_exe_pred;
    logic             w_mispredict;
    logic             w_flush_nxt;
    logic             w_alloc;
    logic             w_train;
    logic             w_has_inv;
    logic [WAY_W-1:0] w_inv_way;
    logic [WAY_W-1:0] w_victim;
    logic             w_lfsr_fb;

    // More than one matching way is treated as a miss rather than picking one.
    function automatic look_t lookup(input logic [PC_W-1:0] pc, input logic isr);
        look_t            res;
        logic [SET_W-1:0] s_idx;
        int               n;
        res   = '0;
        n     = 0;
        s_idx = pc[SET_W-1:0];
        for (int w = 0; w < WAYS; w++) begin
            if (r_valid[s_idx][w] && (r_tag[s_idx][w] == {isr, pc[PC_W-1:SET_W]})) begin
                n       = n + 1;
                res.way = WAY_W'(w);
            end
        end
        res.hit = (n == 1);
        return res;
    endfunction

    assign w_busy    = (r_state == S_SWEEP);
    assign w_if_set  = if_pc[SET_W-1:0];
    assign w_id_set  = id_pc[SET_W-1:0];
    assign w_exe_set = exe_pc[SET_W-1:0];

    always_comb begin
        w_if_lk  = lookup(if_pc, isr_running);
        w_id_lk  = lookup(id_pc, isr_running);
        w_exe_lk = lookup(exe_pc, isr_running);
    end

    assign w_if_hit  = !w_busy && w_if_lk.hit;
    assign w_id_hit  = !w_busy && w_id_lk.hit;
    assign w_exe_hit = !w_busy && w_exe_lk.hit;

    assign inv_busy       = w_busy;
    assign if_hit         = w_if_hit;
    assign if_prediction  = w_if_hit && r_ctr[w_if_set][w_if_lk.way][CTR_W-1];
    assign if_pbt         = w_if_hit ? r_tgt[w_if_set][w_if_lk.way] : '0;
    assign id_jump_in_bht = id_is_jump && w_id_hit;

    assign w_exe_ctr      = r_ctr[w_exe_set][w_exe_lk.way];
    assign w_exe_pred     = w_exe_hit && w_exe_ctr[CTR_W-1];
    assign w_mispredict   = !w_busy && exe_is_branch && (w_exe_pred != exe_taken);
    assign exe_correction = w_mispredict ? {1'b1, exe_taken} : 2'b00;
    assign exe_pbt        = w_exe_hit ? r_tgt[w_exe_set][w_exe_lk.way] : '0;
    assign exe_cni        = exe_pc + PC_W'(1);
    assign flush          = r_flush_state || w_mispredict;

    // A mispredict flushes for two cycles; an unknown jump in ID flushes the cycle after.
    always_comb begin
        w_flush_nxt = 1'b0;
        if (r_flush_state) begin
            w_flush_nxt = 1'b0;
        end else if (w_mispredict) begin
            w_flush_nxt = 1'b1;
        end else begin
            w_flush_nxt = !w_busy && id_is_jump && !w_id_lk.hit;
        end
    end

    always_comb begin
        w_has_inv = 1'b0;
        w_inv_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!r_valid[w_id_set][w]) begin
                w_has_inv = 1'b1;
                w_inv_way = WAY_W'(w);
            end
        end
        w_victim = w_inv_way;
        if (!w_has_inv) begin
            if (REPL == 0) begin
                w_victim = r_fifo[w_id_set];
            end else begin
                w_victim = r_lfsr[WAY_W-1:0];
            end
        end
    end

    assign w_alloc     = en && !stall && !w_busy && (id_is_jump || id_is_btype) && !w_id_lk.hit;
    assign w_alloc_ctr = id_is_jump ? CTR_MAX : CTR_WEAK;
    assign w_train     = en && !stall && !w_busy && exe_is_branch && w_exe_lk.hit
                         && !(w_alloc && (w_id_set == w_exe_set) && (w_victim == w_exe_lk.way));

    always_comb begin
        w_ctr_trained = w_exe_ctr;
        if (exe_taken) begin
            if (w_exe_ctr != CTR_MAX) begin
                w_ctr_trained = w_exe_ctr + CTR_W'(1);
            end
        end else if (w_exe_ctr != '0) begin
            w_ctr_trained = w_exe_ctr - CTR_W'(1);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (inv_req) w_state_nxt = S_SWEEP;
            S_SWEEP: if (r_sweep_idx == {SET_W{1'b1}}) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_lfsr_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

    always_ff @(posedge CLK) begin
        if (!nrst) begin
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_fifo[s]  <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    r_ctr[s][w] <= '0;
                end
            end
            r_lfsr        <= 8'h01;
            r_flush_state <= 1'b0;
            r_state       <= S_IDLE;
            r_sweep_idx   <= '0;
        end else if (en) begin
            r_lfsr        <= {r_lfsr[6:0], w_lfsr_fb};
            r_flush_state <= w_flush_nxt;
            r_state       <= w_state_nxt;
            if (w_busy) begin
                r_valid[r_sweep_idx] <= '0;
                r_fifo[r_sweep_idx]  <= '0;
                r_sweep_idx          <= r_sweep_idx + SET_W'(1);
            end else if (inv_req) begin
                r_sweep_idx <= '0;
            end
            if (w_train) begin
                r_ctr[w_exe_set][w_exe_lk.way] <= w_ctr_trained;
            end
            if (w_alloc) begin
                r_valid[w_id_set][w_victim] <= 1'b1;
                r_ctr[w_id_set][w_victim]   <= w_alloc_ctr;
                if (!w_has_inv && (REPL == 0)) begin
                    r_fifo[w_id_set] <= r_fifo[w_id_set] + WAY_W'(1);
                end
            end
        end
    end

    // Tag and target payload are only meaningful under a valid bit, so they carry no reset.
    always_ff @(posedge CLK) begin
        if (w_alloc) begin
            r_tag[w_id_set][w_victim] <= {isr_running, id_pc[PC_W-1:SET_W]};
            r_tgt[w_id_set][w_victim] <= id_target;
        end
    end

endmodule

// File: tb/tb_bht_assoc_param.sv
// Directed and randomised bench for bht_assoc_param with default parameters,
// checked every cycle against a table-level reference model.
module tb_bht_assoc_param;

    localparam int SETS = 16;
    localparam int WAYS = 4;
    localparam int CMAX = 3;
    localparam int CMID = 2;

    logic       CLK = 1'b0;
    logic       nrst, en, stall, isr_running, inv_req, inv_busy;
    logic [9:0] if_pc, if_pbt, id_pc, id_target, exe_pc, exe_pbt, exe_cni;
    logic       if_hit, if_prediction, id_is_jump, id_is_btype, id_jump_in_bht;
    logic       exe_is_branch, exe_taken, flush;
    logic [1:0] exe_correction;

    always #5 CLK = ~CLK;

    bht_assoc_param dut (
        .CLK(CLK), .nrst(nrst), .en(en), .stall(stall), .isr_running(isr_running),
        .inv_req(inv_req), .inv_busy(inv_busy),
        .if_pc(if_pc), .if_hit(if_hit), .if_prediction(if_prediction), .if_pbt(if_pbt),
        .id_pc(id_pc), .id_target(id_target), .id_is_jump(id_is_jump),
        .id_is_btype(id_is_btype), .id_jump_in_bht(id_jump_in_bht),
        .exe_pc(exe_pc), .exe_is_branch(exe_is_branch), .exe_taken(exe_taken),
        .exe_correction(exe_correction), .exe_pbt(exe_pbt), .exe_cni(exe_cni),
        .flush(flush)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference table: tag is the word address above the set bits plus 64 for ISR context.
    bit m_valid [SETS][WAYS];
    int m_tag   [SETS][WAYS];
    int m_tgt   [SETS][WAYS];
    int m_ctr   [SETS][WAYS];
    int m_fifo  [SETS];
    bit m_fs, m_sweep, m_known;
    int m_idx;

    function automatic void mlook(input int pc, input bit isr, output bit hit, output int way);
        int s = pc % SETS;
        int n = 0;
        way = 0;
        for (int w = 0; w < WAYS; w++) begin
            if (m_valid[s][w] && m_tag[s][w] == int'(isr) * 64 + pc / SETS) begin
                n++;
                way = w;
            end
        end
        hit = (n == 1) && !m_sweep;
    endfunction

    task automatic compare_outputs();
        bit h, pred, mis;
        int w, s;
        if (!m_known) return;
        chk("inv_busy", inv_busy, m_sweep);
        mlook(if_pc, isr_running, h, w);
        s = if_pc % SETS;
        chk("if_hit", if_hit, h);
        chk("if_prediction", if_prediction, h && m_ctr[s][w] >= CMID);
        chk("if_pbt", if_pbt, h ? m_tgt[s][w] : 0);
        mlook(id_pc, isr_running, h, w);
        chk("id_jump_in_bht", id_jump_in_bht, id_is_jump && h);
        mlook(exe_pc, isr_running, h, w);
        s    = exe_pc % SETS;
        pred = h && m_ctr[s][w] >= CMID;
        mis  = !m_sweep && exe_is_branch && (pred != exe_taken);
        chk("exe_correction", exe_correction, mis ? (exe_taken ? 3 : 2) : 0);
        chk("exe_pbt", exe_pbt, h ? m_tgt[s][w] : 0);
        chk("exe_cni", exe_cni, (int'(exe_pc) + 1) % 1024);
        chk("flush", flush, m_fs || mis);
    endtask

    task automatic model_step();
        bit hid, hex, pred, mis, nfs, alloc, train, from_ptr;
        int wid, wex, sid, sex, vic;
        if (!nrst) begin
            for (int s = 0; s < SETS; s++) begin
                m_fifo[s] = 0;
                for (int w = 0; w < WAYS; w++) begin
                    m_valid[s][w] = 0;
                    m_ctr[s][w]   = 0;
                end
            end
            m_fs = 0; m_sweep = 0; m_idx = 0; m_known = 1;
            return;
        end
        if (!m_known || !en) return;
        sid = id_pc % SETS;
        sex = exe_pc % SETS;
        mlook(id_pc, isr_running, hid, wid);
        mlook(exe_pc, isr_running, hex, wex);
        pred  = hex && m_ctr[sex][wex] >= CMID;
        mis   = !m_sweep && exe_is_branch && (pred != exe_taken);
        nfs   = m_fs ? 0 : (mis ? 1 : (!m_sweep && id_is_jump && !hid));
        alloc = !stall && !m_sweep && (id_is_jump || id_is_btype) && !hid;
        vic   = -1;
        for (int w = WAYS - 1; w >= 0; w--) if (!m_valid[sid][w]) vic = w;
        from_ptr = (vic < 0);
        if (from_ptr) vic = m_fifo[sid];
        train = !stall && !m_sweep && exe_is_branch && hex && !(alloc && sid == sex && vic == wex);
        if (train) begin
            if (exe_taken) m_ctr[sex][wex] = (m_ctr[sex][wex] < CMAX) ? m_ctr[sex][wex] + 1 : CMAX;
            else           m_ctr[sex][wex] = (m_ctr[sex][wex] > 0) ? m_ctr[sex][wex] - 1 : 0;
        end
        if (alloc) begin
            m_valid[sid][vic] = 1;
            m_tag[sid][vic]   = int'(isr_running) * 64 + id_pc / SETS;
            m_tgt[sid][vic]   = id_target;
            m_ctr[sid][vic]   = id_is_jump ? CMAX : CMID - 1;
            if (from_ptr) m_fifo[sid] = (m_fifo[sid] + 1) % WAYS;
        end
        if (m_sweep) begin
            for (int w = 0; w < WAYS; w++) m_valid[m_idx][w] = 0;
            m_fifo[m_idx] = 0;
            if (m_idx == SETS - 1) m_sweep = 0;
            else                   m_idx++;
        end else if (inv_req) begin
            m_sweep = 1;
            m_idx   = 0;
        end
        m_fs = nfs;
    endtask

    task automatic tick();
        @(negedge CLK);
        compare_outputs();
        @(posedge CLK);
        model_step();
        #1;
    endtask

    task automatic idle();
        nrst = 1; en = 1; stall = 0; isr_running = 0; inv_req = 0;
        if_pc = '0; id_pc = '0; id_target = '0; id_is_jump = 0; id_is_btype = 0;
        exe_pc = '0; exe_is_branch = 0; exe_taken = 0;
    endtask

    function automatic logic [9:0] rpc();
        if ($urandom_range(0, 15) == 0) return 10'h3ff;
        return 10'(($urandom_range(0, 5) << 4) | $urandom_range(0, 3));
    endfunction

    task automatic alloc_branch(input logic [9:0] pc, input logic [9:0] tgt);
        idle();
        id_pc = pc; id_target = tgt; id_is_btype = 1;
        tick();
    endtask

    initial begin
        int n;
        m_known = 0; m_sweep = 0; m_fs = 0; m_idx = 0;
        idle();
        nrst = 0;
        tick();
        tick();
        nrst = 1; if_pc = 10'h025; #1;
        chk("rst_inv_busy", inv_busy, 0);
        chk("rst_if_hit", if_hit, 0);
        chk("rst_if_pred", if_prediction, 0);
        chk("rst_if_pbt", if_pbt, 0);
        chk("rst_flush", flush, 0);
        chk("rst_corr", exe_correction, 0);

        alloc_branch(10'h025, 10'h040);
        idle(); if_pc = 10'h025; #1;
        chk("alloc_hit", if_hit, 1);
        chk("alloc_pred", if_prediction, 0);
        chk("alloc_pbt", if_pbt, 10'h040);
        exe_pc = 10'h025; exe_is_branch = 1; exe_taken = 1; #1;
        chk("res1_corr", exe_correction, 2'b11);
        chk("res1_flush", flush, 1);
        tick();
        chk("res2_corr", exe_correction, 2'b00);
        chk("res2_flush", flush, 1);
        tick();
        chk("res3_corr", exe_correction, 2'b00);
        chk("res3_flush", flush, 0);
        tick();
        exe_taken = 0; #1;
        chk("res4_corr", exe_correction, 2'b10);
        tick();
        idle(); if_pc = 10'h025; #1;
        chk("res4_ctr_msb", if_prediction, 1);
        chk("res4_flush2", flush, 1);
        tick();

        nrst = 0; tick();
        for (int t = 0; t < 5; t++) alloc_branch(10'(t * 16 + 5), 10'(t + 1));
        idle(); if_pc = 10'h005; #1;
        chk("evict_tag0_miss", if_hit, 0);
        if_pc = 10'h045; #1;
        chk("evict_tag4_hit", if_hit, 1);
        chk("evict_tag4_pbt", if_pbt, 5);
        if_pc = 10'h015; #1;
        chk("evict_tag1_hit", if_hit, 1);
        tick();

        idle(); id_pc = 10'h100; id_target = 10'h200; id_is_jump = 1; #1;
        chk("jmp_miss_flush", flush, 0);
        chk("jmp_miss_jib", id_jump_in_bht, 0);
        tick();
        idle(); #1;
        chk("jmp_miss_flush_next", flush, 1);
        tick();
        id_pc = 10'h100; id_is_jump = 1; #1;
        chk("jmp_hit_jib", id_jump_in_bht, 1);
        chk("jmp_hit_flush", flush, 0);
        tick();
        idle(); #1;
        chk("jmp_hit_flush_next", flush, 0);

        inv_req = 1; tick();
        idle(); if_pc = 10'h045; #1;
        chk("sweep_busy", inv_busy, 1);
        chk("sweep_if_masked", if_hit, 0);
        n = 0;
        while (inv_busy === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        chk("sweep_len", n, 16);
        chk("post_sweep_miss_a", if_hit, 0);
        if_pc = 10'h100; #1;
        chk("post_sweep_miss_b", if_hit, 0);

        alloc_branch(10'h033, 10'h001);
        idle(); inv_req = 1; tick();
        inv_req = 0;
        repeat (7) tick();
        chk("sweep_mid_busy", inv_busy, 1);
        nrst = 0; tick();
        nrst = 1; #1;
        chk("sweep_reset_busy", inv_busy, 0);

        for (int t = 0; t < 4; t++) alloc_branch(10'(t * 16 + 3), 10'(10'h0a0 + t));
        idle();
        exe_pc = 10'h003; exe_is_branch = 1; exe_taken = 1;
        id_pc = 10'h043; id_target = 10'h111; id_is_btype = 1; #1;
        chk("same_corr", exe_correction, 2'b11);
        tick();
        idle(); if_pc = 10'h043; #1;
        chk("same_alloc_hit", if_hit, 1);
        chk("same_alloc_pbt", if_pbt, 10'h111);
        chk("same_alloc_pred", if_prediction, 0);
        if_pc = 10'h003; #1;
        chk("same_old_miss", if_hit, 0);
        if_pc = 10'h043; isr_running = 1; #1;
        chk("isr_miss", if_hit, 0);
        tick();

        for (int c = 0; c < 3000; c++) begin
            nrst          = ($urandom_range(0, 199) != 0);
            en            = ($urandom_range(0, 9) != 0);
            stall         = ($urandom_range(0, 4) == 0);
            isr_running   = ($urandom_range(0, 4) == 0);
            inv_req       = ($urandom_range(0, 99) == 0);
            if_pc         = rpc();
            id_pc         = rpc();
            exe_pc        = rpc();
            id_target     = 10'($urandom);
            id_is_jump    = ($urandom_range(0, 3) == 0);
            id_is_btype   = ($urandom_range(0, 1) == 0);
            exe_is_branch = ($urandom_range(0, 1) == 0);
            exe_taken     = ($urandom_range(0, 1) == 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
